// File: rtl/multicycle_main_fsm_pkg.sv
// Shared encodings for the multi-cycle main control FSM: opcodes, state
// codes and datapath mux-select values.
package multicycle_main_fsm_pkg;

  // RV32I opcodes handled by the core
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // FSM state encoding
  typedef logic [3:0] state_t;
  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEMADR   = 4'd2;
  localparam state_t S_MEMREAD  = 4'd3;
  localparam state_t S_MEMWB    = 4'd4;
  localparam state_t S_MEMWRITE = 4'd5;
  localparam state_t S_EXECR    = 4'd6;
  localparam state_t S_EXECI    = 4'd7;
  localparam state_t S_ALUWB    = 4'd8;
  localparam state_t S_JAL      = 4'd9;
  localparam state_t S_BEQ      = 4'd10;
  localparam state_t S_TRAP     = 4'd11;

  // Result mux
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // ALU A mux
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU B mux
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ALU operation class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Immediate formats
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Trap causes
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/multicycle_main_fsm_instr_type_decoder.sv
// Combinational opcode classifier: immediate format and legality.
// Kept separate so the pipelined core can reuse it in its decode stage.
module instr_type_decoder
  import multicycle_main_fsm_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic [1:0] imm_src_o,
  output logic       legal_o
);

  // Map opcode to immediate format and flag the opcodes the core supports
  always_comb begin
    imm_src_o = IMM_I;
    legal_o   = 1'b1;
    case (opcode_i)
      OP_LW:   imm_src_o = IMM_I;
      OP_I:    imm_src_o = IMM_I;
      OP_R:    imm_src_o = IMM_I;
      OP_SW:   imm_src_o = IMM_S;
      OP_BEQ:  imm_src_o = IMM_B;
      OP_JAL:  imm_src_o = IMM_J;
      default: begin
        imm_src_o = IMM_I;
        legal_o   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multi-cycle core. Sequences each instruction,
// drives datapath selects/enables, and owns the memory-wait timeout,
// illegal-opcode trap and retired-instruction counter.
module multicycle_main_fsm
  import multicycle_main_fsm_pkg::*;
#(
  parameter int TIMEOUT    = 16,
  parameter int CNT_WIDTH  = 32,
  parameter int WAIT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic                 memReady,
  input  logic                 zero,
  output logic                 pcWrite,
  output logic                 IRWrite,
  output logic                 adrSrc,
  output logic                 memWrite,
  output logic                 regWrite,
  output logic [1:0]           resultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           immSrc,
  output logic [1:0]           ALUOpcode,
  output logic                 trap,
  output logic [1:0]           trapCause,
  output logic [CNT_WIDTH-1:0] instret
);

  localparam bit TIMEOUT_EN = (TIMEOUT != 32'sd0);
  localparam logic [WAIT_WIDTH-1:0] TIMEOUT_LAST = WAIT_WIDTH'(TIMEOUT - 32'sd1);

  state_t                state_q, state_d;
  logic [1:0]            cause_q, cause_d;
  logic [WAIT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_WIDTH-1:0]  instret_q, instret_d;
  logic                  legal_s;
  logic                  waiting_s;
  logic                  timeout_s;
  logic                  retire_s;

  instr_type_decoder u_decoder (
    .opcode_i  (opcode),
    .imm_src_o (immSrc),
    .legal_o   (legal_s)
  );

  // Detect a stalled memory access and the cycle on which it times out
  always_comb begin
    waiting_s = 1'b0;
    timeout_s = 1'b0;
    case (state_q)
      S_FETCH, S_MEMREAD, S_MEMWRITE: waiting_s = ~memReady;
      default:                        waiting_s = 1'b0;
    endcase
    if (TIMEOUT_EN && waiting_s && (wait_cnt_q == TIMEOUT_LAST)) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Next-state and trap-cause selection
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH: begin
        if (timeout_s) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else if (memReady) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        if (!legal_s) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          case (opcode)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_R:         state_d = S_EXECR;
            OP_I:         state_d = S_EXECI;
            OP_JAL:       state_d = S_JAL;
            OP_BEQ:       state_d = S_BEQ;
            default: begin
              state_d = S_TRAP;
              cause_d = CAUSE_ILLEGAL;
            end
          endcase
        end
      end
      S_MEMADR: begin
        if (opcode == OP_SW) begin
          state_d = S_MEMWRITE;
        end else begin
          state_d = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        if (timeout_s) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else if (memReady) begin
          state_d = S_MEMWB;
        end else begin
          state_d = S_MEMREAD;
        end
      end
      S_MEMWRITE: begin
        if (timeout_s) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else if (memReady) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MEMWRITE;
        end
      end
      S_MEMWB:  state_d = S_FETCH;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_JAL:    state_d = S_ALUWB;
      S_BEQ:    state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  // Wait counter and retire counter next values
  always_comb begin
    wait_cnt_d = {WAIT_WIDTH{1'b0}};
    retire_s   = 1'b0;
    if ((state_d != state_q) || memReady) begin
      wait_cnt_d = {WAIT_WIDTH{1'b0}};
    end else if (waiting_s) begin
      wait_cnt_d = wait_cnt_q + {{(WAIT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      wait_cnt_d = {WAIT_WIDTH{1'b0}};
    end
    case (state_q)
      S_MEMWB, S_ALUWB, S_BEQ, S_MEMWRITE: retire_s = (state_d == S_FETCH);
      default:                             retire_s = 1'b0;
    endcase
    instret_d = instret_q + {{(CNT_WIDTH-1){1'b0}}, retire_s};
  end

  // State, cause and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      cause_q    <= CAUSE_NONE;
      wait_cnt_q <= {WAIT_WIDTH{1'b0}};
      instret_q  <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      wait_cnt_q <= wait_cnt_d;
      instret_q  <= instret_d;
    end
  end

  // Datapath controls decoded from the current state
  always_comb begin
    pcWrite   = 1'b0;
    IRWrite   = 1'b0;
    adrSrc    = 1'b0;
    memWrite  = 1'b0;
    regWrite  = 1'b0;
    resultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RS2;
    ALUOpcode = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        resultSrc = RES_ALURES;
        IRWrite   = memReady;
        pcWrite   = memReady;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: adrSrc = 1'b1;
      S_MEMWB: begin
        regWrite  = 1'b1;
        resultSrc = RES_RDATA;
      end
      S_MEMWRITE: begin
        adrSrc   = 1'b1;
        memWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        ALUOpcode = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        ALUOpcode = ALUOP_FUNCT;
      end
      S_ALUWB: regWrite = 1'b1;
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        pcWrite = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        ALUOpcode = ALUOP_SUB;
        pcWrite   = zero;
      end
      default: pcWrite = 1'b0;
    endcase
  end

  assign trap      = (state_q == S_TRAP);
  assign trapCause = cause_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed bench for multicycle_main_fsm (TIMEOUT=4).
module tb_multicycle_main_fsm;

  logic        clk = 1'b0;
  logic        reset, memReady, zero;
  logic [6:0]  opcode;
  logic        pcWrite, IRWrite, adrSrc, memWrite, regWrite, trap;
  logic [1:0]  resultSrc, ALUSrcA, ALUSrcB, immSrc, ALUOpcode, trapCause;
  logic [31:0] instret;
  logic [15:0] obs;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_instret = 32'd0;

  // Output word: pcW IRW adr memW regW | res[2] A[2] B[2] op[2] | trap cause[2]
  localparam logic [15:0] E_FETCH_RDY  = 16'b1_1_0_0_0_10_00_10_00_0_00;
  localparam logic [15:0] E_FETCH_IDLE = 16'b0_0_0_0_0_10_00_10_00_0_00;
  localparam logic [15:0] E_DECODE     = 16'b0_0_0_0_0_00_01_01_00_0_00;
  localparam logic [15:0] E_MEMADR     = 16'b0_0_0_0_0_00_10_01_00_0_00;
  localparam logic [15:0] E_MEMREAD    = 16'b0_0_1_0_0_00_00_00_00_0_00;
  localparam logic [15:0] E_MEMWB      = 16'b0_0_0_0_1_01_00_00_00_0_00;
  localparam logic [15:0] E_MEMWRITE   = 16'b0_0_1_1_0_00_00_00_00_0_00;
  localparam logic [15:0] E_EXECR      = 16'b0_0_0_0_0_00_10_00_10_0_00;
  localparam logic [15:0] E_EXECI      = 16'b0_0_0_0_0_00_10_01_10_0_00;
  localparam logic [15:0] E_ALUWB      = 16'b0_0_0_0_1_00_00_00_00_0_00;
  localparam logic [15:0] E_JAL        = 16'b1_0_0_0_0_00_01_10_00_0_00;
  localparam logic [15:0] E_BEQ_T      = 16'b1_0_0_0_0_00_10_00_01_0_00;
  localparam logic [15:0] E_BEQ_N      = 16'b0_0_0_0_0_00_10_00_01_0_00;
  localparam logic [15:0] E_TRAP_ILL   = 16'b0_0_0_0_0_00_00_00_00_1_01;
  localparam logic [15:0] E_TRAP_TO    = 16'b0_0_0_0_0_00_00_00_00_1_10;

  always #5 clk = ~clk;

  assign obs = {pcWrite, IRWrite, adrSrc, memWrite, regWrite,
                resultSrc, ALUSrcA, ALUSrcB, ALUOpcode, trap, trapCause};

  multicycle_main_fsm #(.TIMEOUT(4), .CNT_WIDTH(32), .WAIT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .memReady(memReady), .zero(zero),
    .pcWrite(pcWrite), .IRWrite(IRWrite), .adrSrc(adrSrc), .memWrite(memWrite),
    .regWrite(regWrite), .resultSrc(resultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .immSrc(immSrc), .ALUOpcode(ALUOpcode), .trap(trap), .trapCause(trapCause),
    .instret(instret)
  );

  task automatic drive(input logic [6:0] op, input logic mr, input logic z);
    opcode = op; memReady = mr; zero = z;
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1; memReady = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; memReady = 1'b0; zero = 1'b0; opcode = 7'd0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    drive(7'd0, 1'b0, 1'b0);
    checks++; if (obs !== E_FETCH_IDLE) begin errors++; $display("FAIL reset_outputs: got %b expected %b", obs, E_FETCH_IDLE); end
    checks++; if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret: got %0d expected 0", instret); end
    next_cycle();
  endtask

  task automatic test_rtype();
    logic [15:0] ev [4];
    ev = '{E_FETCH_RDY, E_DECODE, E_EXECR, E_ALUWB};
    for (int i = 0; i < 4; i++) begin
      drive(7'b0110011, 1'b1, 1'b0);
      checks++; if (obs !== ev[i]) begin errors++; $display("FAIL rtype_c%0d: got %b expected %b", i, obs, ev[i]); end
      if (i == 3) begin
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL rtype_instret_before: got %0d expected %0d", instret, exp_instret); end
      end
      next_cycle();
    end
    exp_instret++;
    drive(7'b0110011, 1'b0, 1'b0);
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL rtype_instret: got %0d expected %0d", instret, exp_instret); end
    checks++; if (immSrc !== 2'b00) begin errors++; $display("FAIL rtype_imm: got %b expected 00", immSrc); end
    next_cycle();
  endtask

  task automatic test_itype_jal();
    logic [15:0] ev_i [4];
    logic [15:0] ev_j [4];
    ev_i = '{E_FETCH_RDY, E_DECODE, E_EXECI, E_ALUWB};
    ev_j = '{E_FETCH_RDY, E_DECODE, E_JAL, E_ALUWB};
    for (int i = 0; i < 4; i++) begin
      drive(7'b0010011, 1'b1, 1'b0);
      checks++; if (obs !== ev_i[i]) begin errors++; $display("FAIL itype_c%0d: got %b expected %b", i, obs, ev_i[i]); end
      next_cycle();
    end
    exp_instret++;
    for (int i = 0; i < 4; i++) begin
      drive(7'b1101111, 1'b1, 1'b0);
      checks++; if (obs !== ev_j[i]) begin errors++; $display("FAIL jal_c%0d: got %b expected %b", i, obs, ev_j[i]); end
      if (i == 0) begin
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL itype_instret: got %0d expected %0d", instret, exp_instret); end
        checks++; if (immSrc !== 2'b11) begin errors++; $display("FAIL jal_imm: got %b expected 11", immSrc); end
      end
      next_cycle();
    end
    exp_instret++;
  endtask

  task automatic test_lw();
    logic [15:0] ev [8];
    logic        mr [8];
    ev = '{E_FETCH_RDY, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMREAD, E_MEMREAD, E_MEMREAD, E_MEMWB};
    mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      drive(7'b0000011, mr[i], 1'b0);
      checks++; if (obs !== ev[i]) begin errors++; $display("FAIL lw_c%0d: got %b expected %b", i, obs, ev[i]); end
      if (i == 0) begin
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL jal_instret: got %0d expected %0d", instret, exp_instret); end
        checks++; if (immSrc !== 2'b00) begin errors++; $display("FAIL lw_imm: got %b expected 00", immSrc); end
      end
      next_cycle();
    end
    exp_instret++;
    drive(7'b0000011, 1'b0, 1'b0);
    checks++; if (obs !== E_FETCH_IDLE) begin errors++; $display("FAIL lw_back_to_fetch: got %b expected %b", obs, E_FETCH_IDLE); end
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL lw_instret: got %0d expected %0d", instret, exp_instret); end
    next_cycle();
  endtask

  task automatic test_sw();
    logic [15:0] ev [6];
    logic        mr [6];
    ev = '{E_FETCH_RDY, E_DECODE, E_MEMADR, E_MEMWRITE, E_MEMWRITE, E_MEMWRITE};
    mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive(7'b0100011, mr[i], 1'b0);
      checks++; if (obs !== ev[i]) begin errors++; $display("FAIL sw_c%0d: got %b expected %b", i, obs, ev[i]); end
      if (i == 0) begin
        checks++; if (immSrc !== 2'b01) begin errors++; $display("FAIL sw_imm: got %b expected 01", immSrc); end
      end
      next_cycle();
    end
    exp_instret++;
    drive(7'b0100011, 1'b0, 1'b0);
    checks++; if (obs !== E_FETCH_IDLE) begin errors++; $display("FAIL sw_memwrite_drop: got %b expected %b", obs, E_FETCH_IDLE); end
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL sw_instret: got %0d expected %0d", instret, exp_instret); end
    next_cycle();
  endtask

  task automatic test_beq();
    logic [15:0] ev [3];
    for (int k = 0; k < 2; k++) begin
      ev = '{E_FETCH_RDY, E_DECODE, (k == 0) ? E_BEQ_T : E_BEQ_N};
      for (int i = 0; i < 3; i++) begin
        drive(7'b1100011, 1'b1, (k == 0) ? 1'b1 : 1'b0);
        checks++; if (obs !== ev[i]) begin errors++; $display("FAIL beq%0d_c%0d: got %b expected %b", k, i, obs, ev[i]); end
        next_cycle();
      end
      exp_instret++;
    end
    drive(7'b1100011, 1'b0, 1'b0);
    checks++; if (obs !== E_FETCH_IDLE) begin errors++; $display("FAIL beq_back_to_fetch: got %b expected %b", obs, E_FETCH_IDLE); end
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL beq_instret: got %0d expected %0d", instret, exp_instret); end
    checks++; if (immSrc !== 2'b10) begin errors++; $display("FAIL beq_imm: got %b expected 10", immSrc); end
    next_cycle();
  endtask

  task automatic test_illegal();
    logic [15:0] ev [5];
    ev = '{E_FETCH_RDY, E_DECODE, E_TRAP_ILL, E_TRAP_ILL, E_TRAP_ILL};
    for (int i = 0; i < 5; i++) begin
      drive(7'b1111111, 1'b1, 1'b1);
      checks++; if (obs !== ev[i]) begin errors++; $display("FAIL illegal_c%0d: got %b expected %b", i, obs, ev[i]); end
      next_cycle();
    end
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL trap_instret_frozen: got %0d expected %0d", instret, exp_instret); end
    pulse_reset();
    exp_instret = 32'd0;
    drive(7'b1111111, 1'b0, 1'b0);
    checks++; if (obs !== E_FETCH_IDLE) begin errors++; $display("FAIL illegal_reset: got %b expected %b", obs, E_FETCH_IDLE); end
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL illegal_reset_instret: got %0d expected 0", instret); end
    next_cycle();
  endtask

  task automatic test_timeout();
    logic [15:0] ev [5];
    logic [15:0] ev2 [7];
    logic        mr2 [7];
    pulse_reset();
    ev = '{E_FETCH_IDLE, E_FETCH_IDLE, E_FETCH_IDLE, E_FETCH_IDLE, E_TRAP_TO};
    for (int i = 0; i < 5; i++) begin
      drive(7'b0110011, 1'b0, 1'b0);
      checks++; if (obs !== ev[i]) begin errors++; $display("FAIL timeout_c%0d: got %b expected %b", i, obs, ev[i]); end
      next_cycle();
    end
    pulse_reset();
    ev2 = '{E_FETCH_IDLE, E_FETCH_IDLE, E_FETCH_IDLE, E_FETCH_RDY, E_DECODE, E_EXECR, E_ALUWB};
    mr2 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      drive(7'b0110011, mr2[i], 1'b0);
      checks++; if (obs !== ev2[i]) begin errors++; $display("FAIL timeout_rescue_c%0d: got %b expected %b", i, obs, ev2[i]); end
      next_cycle();
    end
    exp_instret++;
    drive(7'b0110011, 1'b0, 1'b0);
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL timeout_rescue_instret: got %0d expected %0d", instret, exp_instret); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    logic [15:0] ev [3];
    ev = '{E_FETCH_RDY, E_DECODE, E_MEMADR};
    for (int i = 0; i < 3; i++) begin
      drive(7'b0000011, 1'b1, 1'b0);
      checks++; if (obs !== ev[i]) begin errors++; $display("FAIL midreset_c%0d: got %b expected %b", i, obs, ev[i]); end
      next_cycle();
    end
    reset = 1'b1;
    drive(7'b0000011, 1'b1, 1'b0);
    checks++; if (obs !== E_MEMREAD) begin errors++; $display("FAIL midreset_memread: got %b expected %b", obs, E_MEMREAD); end
    next_cycle();
    reset = 1'b0;
    exp_instret = 32'd0;
    drive(7'b0000011, 1'b0, 1'b0);
    checks++; if (obs !== E_FETCH_IDLE) begin errors++; $display("FAIL midreset_no_strobe: got %b expected %b", obs, E_FETCH_IDLE); end
    checks++; if (instret !== exp_instret) begin errors++; $display("FAIL midreset_instret: got %0d expected 0", instret); end
    next_cycle();
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_rtype();
    test_itype_jal();
    test_lw();
    test_sw();
    test_beq();
    test_illegal();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
